// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, 27-bit binary to 8 packed BCD digits.
// Out-of-range inputs bypass the shifter and publish OVF_CODE one cycle after acceptance.
module bin2bcd_seq #(
   parameter logic [31:0] OVF_CODE = 32'hEEEE_EEEE
) (
   input  logic        Clk,
   input  logic        Reset_N,
   input  logic        Start,
   input  logic [26:0] Bin_In,
   output logic        Busy,
   output logic        Done,
   output logic        Ovf,
   output logic [31:0] Disp_Data
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state, state_nxt;
   logic [31:0] bcd, bcd_adj;
   logic [26:0] bin;
   logic [4:0]  cnt;
   logic        ovf_pend;
   logic        accept, in_range;
   assign in_range = Bin_In <= 27'd99_999_999;
   // an overflow publish is still pending in IDLE, so a new request must wait for it
   assign accept   = Start && state == IDLE && !ovf_pend;
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 8; i++)
         bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = accept && in_range ? SHIFT : IDLE;
         SHIFT:   state_nxt = cnt == 5'd26 ? DONE : SHIFT;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge Clk or negedge Reset_N)
      if (!Reset_N) state <= IDLE;
      else          state <= state_nxt;
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         bcd       <= '0;
         bin       <= '0;
         cnt       <= '0;
         ovf_pend  <= 1'b0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         Ovf       <= 1'b0;
         Disp_Data <= '0;
      end else begin
         Done <= 1'b0;
         if (accept) begin
            bin      <= Bin_In;
            bcd      <= '0;
            cnt      <= '0;
            Busy     <= in_range;
            ovf_pend <= !in_range;
         end
         if (state == SHIFT) begin
            {bcd, bin} <= {bcd_adj, bin} << 1;
            cnt        <= cnt + 5'd1;
         end
         if (state == DONE) begin
            Disp_Data <= bcd;
            Ovf       <= 1'b0;
            Done      <= 1'b1;
            Busy      <= 1'b0;
         end
         if (ovf_pend) begin
            Disp_Data <= OVF_CODE;
            Ovf       <= 1'b1;
            Done      <= 1'b1;
            ovf_pend  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and random conversions checked against a decimal-digit reference.
module tb_bin2bcd_seq;
   logic        Clk = 1'b0;
   logic        Reset_N = 1'b1;
   logic        Start = 1'b0;
   logic [26:0] Bin_In = '0;
   logic        Busy, Done, Ovf;
   logic [31:0] Disp_Data;
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] disp_exp = '0;
   logic        ovf_exp = 1'b0;
   bin2bcd_seq dut (
      .Clk(Clk), .Reset_N(Reset_N), .Start(Start), .Bin_In(Bin_In),
      .Busy(Busy), .Done(Done), .Ovf(Ovf), .Disp_Data(Disp_Data)
   );
   always #5 Clk = ~Clk;
   function automatic logic [31:0] model(input int unsigned v);
      logic [31:0] r;
      r = '0;
      if (v > 99_999_999) return 32'hEEEE_EEEE;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // counts Done pulses and Busy-high cycles over n cycles; both must stay zero
   task automatic quiet(input string tag, input int n);
      int d, b;
      d = 0;
      b = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge Clk); #1;
         d += int'(Done);
         b += int'(Busy);
      end
      chk({tag, "_done"}, d, 0);
      chk({tag, "_busy"}, b, 0);
   endtask
   // poke >= 0 pulses a second Start (value 7) so that it lands on edge k+poke+1
   task automatic conv(input logic [26:0] v, input int poke, input bit b2b);
      int lat, busy_n;
      logic [31:0] exp;
      logic eo;
      exp = model(v);
      eo  = v > 99_999_999;
      @(negedge Clk); Bin_In = v; Start = 1'b1;
      @(posedge Clk); #1; Start = 1'b0; Bin_In = 27'($urandom);
      lat = 0;
      busy_n = 0;
      do begin
         busy_n += int'(Busy);
         chk("hold_disp", Disp_Data, disp_exp);
         chk("hold_ovf", Ovf, ovf_exp);
         if (lat == poke) begin Start = 1'b1; Bin_In = 27'd7; end
         @(posedge Clk); #1; lat++;
         Start = 1'b0;
      end while (!Done && lat < 40);
      chk("latency", lat, eo ? 1 : 28);
      chk("busy_cycles", busy_n, eo ? 0 : 28);
      chk("disp", Disp_Data, exp);
      chk("ovf", Ovf, eo);
      disp_exp = exp;
      ovf_exp  = eo;
      if (!b2b) begin
         @(posedge Clk); #1;
         chk("done_pulse", Done, 0);
      end
   endtask
   initial begin
      #2 Reset_N = 1'b0;
      #1;
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_ovf", Ovf, 0);
      chk("rst_disp", Disp_Data, 0);
      @(posedge Clk); #2 Reset_N = 1'b1;
      conv(27'd12_345_678, -1, 0);
      chk("disp_12345678", Disp_Data, 32'h1234_5678);
      conv(27'd0, -1, 0);
      conv(27'd99_999_999, -1, 0);
      chk("disp_max", Disp_Data, 32'h9999_9999);
      conv(27'd9, -1, 0);
      conv(27'd100_000_000, -1, 0);
      chk("disp_ovf", Disp_Data, 32'hEEEE_EEEE);
      conv(27'd42, 4, 0);
      quiet("no_queue", 32);
      chk("disp_42", Disp_Data, 32'h0000_0042);
      @(negedge Clk); Bin_In = 27'd777; Start = 1'b1;
      @(posedge Clk); #1; Start = 1'b0;
      repeat (10) @(posedge Clk);
      #3 Reset_N = 1'b0;
      #1;
      chk("abort_busy", Busy, 0);
      chk("abort_done", Done, 0);
      chk("abort_ovf", Ovf, 0);
      chk("abort_disp", Disp_Data, 0);
      quiet("abort", 30);
      @(posedge Clk); #2 Reset_N = 1'b1;
      disp_exp = '0;
      ovf_exp  = 1'b0;
      conv(27'd555, -1, 0);
      conv(27'd1_000, -1, 1);
      conv(27'd2_000, -1, 0);
      chk("disp_2000", Disp_Data, 32'h0000_2000);
      for (int n = 0; n < 20; n++) begin
         case (n % 3)
            0:       conv(27'($urandom_range(0, 99_999_999)), -1, n % 4 == 1);
            1:       conv(27'($urandom), -1, 0);
            default: conv(27'($urandom_range(0, 999)), -1, 0);
         endcase
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter: OVF_CODE, 32'hEEEE_EEEE, packed value shown on Disp_Data when the input is out of range.
REQ-002 SHALL have port: Clk  input  1  rising-edge system clock.
REQ-003 SHALL have port: Reset_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: Start  input  1  conversion request, sampled on Clk rising edge.
REQ-005 SHALL have port: Bin_In  input  27  unsigned binary value to convert.
REQ-006 SHALL have port: Busy  output  1  conversion in progress.
REQ-007 SHALL have port: Done  output  1  one-cycle pulse, result updated.
REQ-008 SHALL have port: Ovf  output  1  last accepted Bin_In exceeded 99_999_999.
REQ-009 SHALL have port: Disp_Data  output  32  packed BCD, 8 digits, digit 0 in [3:0], digit 7 in [31:28], for the 8-digit scanner.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs registered.
REQ-011 SHALL accept Start only in IDLE; Start in SHIFT or DONE ignored, no queuing.
REQ-012 SHALL capture Bin_In only at the accepting edge; later Bin_In changes have no effect on the running conversion.
REQ-013 SHALL, on accept at edge k with Bin_In <= 99_999_999: load shift reg, clear 32-bit BCD work reg and 5-bit counter, enter SHIFT.
REQ-014 SHALL, each SHIFT cycle: add 3 to every work nibble >= 5, then shift {BCD,bin} left 1 bit; exactly 27 shifts on edges k+1..k+27; enter DONE at edge k+27.
REQ-015 SHALL, at edge k+28 in DONE: load Disp_Data with work BCD, clear Ovf, assert Done for one cycle, return to IDLE.
REQ-016 SHALL, on accept at edge k with Bin_In > 99_999_999: skip SHIFT; at edge k+1 load Disp_Data = OVF_CODE, set Ovf, pulse Done, stay IDLE.
REQ-017 SHALL drive Busy high from edge k through edge k+28 (28 cycles) for in-range input; Busy stays low for overflow path.
REQ-018 SHALL hold Disp_Data and Ovf unchanged between Done pulses, so the downstream display never shows partial results.
REQ-019 SHALL accept a Start present in the same cycle Done is high (FSM already IDLE): back-to-back conversions with no idle cycle.
REQ-020 SHALL never leave a BCD nibble > 9 for in-range inputs; 32-bit work reg sized so no digit carry is lost.

Reset
REQ-021 SHALL, while Reset_N low, force immediately: state IDLE, Disp_Data 32'h0, Busy 0, Done 0, Ovf 0, counter 0.
REQ-022 SHALL abort any conversion on reset mid-operation; no Done pulse for aborted conversion.
REQ-023 SHALL accept Start on the first rising edge after Reset_N deasserts.

Verification
REQ-024 SHALL test: Bin_In=12_345_678, Start 1 cycle -> Busy 28 cycles, Done one cycle at edge k+28, Disp_Data=32'h1234_5678, Ovf=0.
REQ-025 SHALL test: Bin_In=0 -> 32'h0000_0000; Bin_In=99_999_999 -> 32'h9999_9999, Ovf=0; Bin_In=9 -> 32'h0000_0009.
REQ-026 SHALL test: Bin_In=100_000_000 -> Done at edge k+1, Disp_Data=32'hEEEE_EEEE, Ovf=1, Busy never high.
REQ-027 SHALL test: Start with 42 then Start with 7 at k+5 (Busy) -> second ignored, Disp_Data=32'h0000_0042, single Done.
REQ-028 SHALL test: Reset_N low at k+10 of a conversion -> all outputs 0 asynchronously, no Done; next Start with 555 -> 32'h0000_0555.
REQ-029 SHALL test: 1_000 then Start held during Done cycle with 2_000 -> Disp_Data=32'h0000_1000 held until second Done, then 32'h0000_2000.
